// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and the helper that derives an
// axis total from its four segment widths.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   function automatic int axis_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Mod-N counter used for one screen axis; exposes its next value so the
// parent can register decodes that line up with the count itself.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int N = 800
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      wrap    = en && (count_q == LAST);
      count_d = count_q;
      if (wrap) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count      = count_q;
   assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock at half CLOCK_50, horizontal/vertical counters
// and registered sync/blank/frame-start strobes aligned with DrawX/DrawY.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       frame_start
);

   localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

   logic             pix_en_q, pix_en_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             blank_n_q, blank_n_d;
   logic             frame_start_q, frame_start_d;

   logic [CNT_W-1:0] x_cnt, x_next, y_cnt, y_next;
   logic             x_wrap, y_wrap;

   vga_axis_counter #(.N(H_TOTAL)) u_h_cnt (
      .clk        (CLOCK_50),
      .rst_n      (RESET_N),
      .en         (pix_en_q),
      .count      (x_cnt),
      .count_next (x_next),
      .wrap       (x_wrap)
   );

   vga_axis_counter #(.N(V_TOTAL)) u_v_cnt (
      .clk        (CLOCK_50),
      .rst_n      (RESET_N),
      .en         (x_wrap),
      .count      (y_cnt),
      .count_next (y_next),
      .wrap       (y_wrap)
   );

   // Decode from the counters' next values so each strobe lands with its coordinate.
   always_comb begin
      pix_en_d      = ~pix_en_q;
      hs_d          = !((x_next >= HS_START) && (x_next < HS_END));
      vs_d          = !((y_next >= VS_START) && (y_next < VS_END));
      blank_n_d     = (x_next < H_VIS_END) && (y_next < V_VIS_END);
      frame_start_d = y_wrap;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         pix_en_q      <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         pix_en_q      <= pix_en_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign VGA_CLK     = pix_en_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b0;
   assign DrawX       = x_cnt;
   assign DrawY       = y_cnt;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default-timing and a tiny-timing instance share clock
// and reset and are compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

   localparam int S_HV = 8, S_HF = 2, S_HS = 2, S_HB = 2;
   localparam int S_VV = 2, S_VF = 2, S_VS = 2, S_VB = 2;

   logic       clk;
   logic       rst_n;
   longint     k;

   logic       d_clk, d_hs, d_vs, d_blank, d_sync, d_fs;
   logic [9:0] d_x, d_y;
   logic       s_clk, s_hs, s_vs, s_blank, s_sync, s_fs;
   logic [9:0] s_x, s_y;

   int         checks;
   int         errors;
   int         max_dx, max_dy, max_sx, max_sy;

   vga_timing_gen u_dut (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .VGA_CLK     (d_clk),
      .VGA_HS      (d_hs),
      .VGA_VS      (d_vs),
      .VGA_BLANK_N (d_blank),
      .VGA_SYNC_N  (d_sync),
      .DrawX       (d_x),
      .DrawY       (d_y),
      .frame_start (d_fs)
   );

   vga_timing_gen #(
      .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
      .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
   ) u_small (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .VGA_CLK     (s_clk),
      .VGA_HS      (s_hs),
      .VGA_VS      (s_vs),
      .VGA_BLANK_N (s_blank),
      .VGA_SYNC_N  (s_sync),
      .DrawX       (s_x),
      .DrawY       (s_y),
      .frame_start (s_fs)
   );

   // 50 MHz system clock
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Count CLOCK_50 edges since reset release; the model derives everything from this
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   // Raster model: after k edges the raster has advanced k/2 pixels
   function automatic logic [24:0] rasterModel(input longint kk,
         input int hv, input int hf, input int hsw, input int hb,
         input int vv, input int vf, input int vsw, input int vb);
      longint ht, vt, p, x, y;
      logic   c, hs, vs, bl, fs;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      p  = kk / 2;
      x  = p % ht;
      y  = (p / ht) % vt;
      c  = (kk % 2) == 1;
      hs = !((x >= hv + hf) && (x < hv + hf + hsw));
      vs = !((y >= vv + vf) && (y < vv + vf + vsw));
      bl = (x < hv) && (y < vv);
      fs = ((kk % 2) == 0) && (p > 0) && ((p % (ht * vt)) == 0);
      return {c, hs, vs, bl, fs, 10'(x), 10'(y)};
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_drawx"}, d_x, 0);
      checkOutput({tag, "_drawy"}, d_y, 0);
      checkOutput({tag, "_vga_clk"}, d_clk, 0);
      checkOutput({tag, "_hs"}, d_hs, 1);
      checkOutput({tag, "_vs"}, d_vs, 1);
      checkOutput({tag, "_blank_n"}, d_blank, 1);
      checkOutput({tag, "_sync_n"}, d_sync, 0);
      checkOutput({tag, "_frame_start"}, d_fs, 0);
   endtask

   task automatic releaseReset();
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   // Drive a random run length followed by an asynchronous reset pulse
   task automatic applyStimulus();
      int run_len, hold;
      run_len = $urandom_range(500, 5000);
      hold    = $urandom_range(1, 4);
      repeat (run_len) @(negedge clk);
      #($urandom_range(1, 8)) rst_n = 1'b0;
      #1 checkOutput("rand_async_reset_drawx", d_x, 0);
      repeat (hold) @(negedge clk);
      releaseReset();
   endtask

   initial begin
      int     n;
      longint last_sk;
      bit     last_sk_valid;
      int     model_fails;
      logic [24:0] act_v, exp_v;

      checks = 0;
      errors = 0;
      max_dx = 0; max_dy = 0; max_sx = 0; max_sy = 0;
      rst_n  = 1'b0;

      // Per-cycle comparison of both instances against the model
      model_fails   = 0;
      last_sk_valid = 0;
      last_sk       = 0;
      fork
         forever begin
            @(negedge clk);
            if (model_fails < 20) begin
               exp_v = rasterModel(k, 640, 16, 96, 48, 480, 10, 2, 33);
               act_v = {d_clk, d_hs, d_vs, d_blank, d_fs, d_x, d_y};
               checks++;
               if (act_v !== exp_v) begin
                  errors++;
                  model_fails++;
                  $display("[TB] FAIL model_default k=%0d actual=%h required=%h", k, act_v, exp_v);
               end
               exp_v = rasterModel(k, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
               act_v = {s_clk, s_hs, s_vs, s_blank, s_fs, s_x, s_y};
               checks++;
               if (act_v !== exp_v) begin
                  errors++;
                  model_fails++;
                  $display("[TB] FAIL model_small k=%0d actual=%h required=%h", k, act_v, exp_v);
               end
            end
            if (k == 0) last_sk_valid = 0;
            if (s_fs) begin
               if (last_sk_valid) checkOutput("small_frame_period", k - last_sk, 224);
               last_sk       = k;
               last_sk_valid = 1;
            end
            if (int'(d_x) > max_dx) max_dx = int'(d_x);
            if (int'(d_y) > max_dy) max_dy = int'(d_y);
            if (int'(s_x) > max_sx) max_sx = int'(s_x);
            if (int'(s_y) > max_sy) max_sy = int'(s_y);
         end
      join_none

      // Reset held for three cycles
      repeat (3) @(negedge clk);
      checkResetValues("reset");

      // Release: pixel clock toggles every cycle, DrawX reaches 5 after 10 edges
      releaseReset();
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("vga_clk_toggle", d_clk, i % 2);
      end
      checkOutput("after10_drawx", d_x, 5);
      checkOutput("after10_drawy", d_y, 0);

      // Blanking edge at DrawX=640, HS low from 656 for 192 cycles
      n = 0;
      while (d_x != 10'd639 && n < 4000) begin @(negedge clk); n++; end
      checkOutput("wait_x639_in_time", n < 4000, 1);
      checkOutput("blank_n_at_639", d_blank, 1);
      n = 0;
      while (d_x != 10'd640 && n < 10) begin @(negedge clk); n++; end
      checkOutput("wait_x640_in_time", n < 10, 1);
      checkOutput("blank_n_at_640", d_blank, 0);
      checkOutput("hs_at_640", d_hs, 1);
      n = 0;
      while (d_x != 10'd656 && n < 100) begin @(negedge clk); n++; end
      checkOutput("wait_x656_in_time", n < 100, 1);
      checkOutput("hs_at_656", d_hs, 0);
      n = 0;
      while (d_hs == 1'b0 && n < 400) begin n++; @(negedge clk); end
      checkOutput("hs_low_cycles", n, 192);
      checkOutput("drawx_after_hs", d_x, 752);

      // Mid-frame reset at (300,200) takes effect before the next edge
      n = 0;
      while (!(d_x == 10'd300 && d_y == 10'd200) && n < 400000) begin @(negedge clk); n++; end
      checkOutput("wait_300_200_in_time", n < 400000, 1);
      #2 rst_n = 1'b0;
      #1 checkResetValues("async_reset");
      repeat (2) @(negedge clk);
      releaseReset();
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("restart_drawx", d_x, 5);
      checkOutput("restart_drawy", d_y, 0);

      // Full frame from that release: VS window and first frame_start
      n = 0;
      while (d_vs != 1'b0 && n < 900000) begin @(negedge clk); n++; end
      checkOutput("wait_vs_in_time", n < 900000, 1);
      checkOutput("vs_start_drawy", d_y, 490);
      checkOutput("vs_start_edge", k, 784000);
      n = 0;
      while (d_vs == 1'b0 && n < 4000) begin n++; @(negedge clk); end
      checkOutput("vs_low_cycles", n, 3200);
      n = 0;
      while (d_fs != 1'b1 && n < 100000) begin @(negedge clk); n++; end
      checkOutput("wait_frame_start_in_time", n < 100000, 1);
      checkOutput("frame_period", k, 840000);
      checkOutput("frame_start_drawx", d_x, 0);
      checkOutput("frame_start_drawy", d_y, 0);
      @(negedge clk);
      checkOutput("frame_start_width", d_fs, 0);
      checkOutput("max_drawx", max_dx, 799);
      checkOutput("max_drawy", max_dy, 524);
      checkOutput("small_max_drawx", max_sx, 13);
      checkOutput("small_max_drawy", max_sy, 7);

      // Randomized runs with asynchronous resets at arbitrary points
      repeat (4) applyStimulus();
      repeat (600) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
